// File: rtl/mon_exp_ctrl.sv
// mon_exp_ctrl: sequencer for Montgomery modular exponentiation, P = X^E mod M.
// It converts the operands into the Montgomery domain, runs left-to-right
// square-and-multiply over E, and converts the result back out. Every product
// is delegated to an external MonPro unit over an mp_start/mp_done handshake.
// Optional feature: define MON_EXP_SKIP_LZ_EN to add a SCAN state that skips
// leading zero exponent bits without issuing products.
module mon_exp_ctrl #(
  parameter int unsigned BIT_LEN = 64,
  parameter int unsigned EXP_LEN = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [BIT_LEN-1:0] X,
  input  logic [EXP_LEN-1:0] E,
  input  logic [BIT_LEN-1:0] M,
  input  logic [BIT_LEN-1:0] R2,
  output logic               busy,
  output logic               done,
  output logic [BIT_LEN-1:0] P,
  output logic               mp_start,
  output logic [BIT_LEN-1:0] mp_a,
  output logic [BIT_LEN-1:0] mp_b,
  output logic [BIT_LEN-1:0] mp_m,
  input  logic               mp_done,
  input  logic [BIT_LEN-1:0] mp_p
);

  localparam logic [BIT_LEN-1:0] One = BIT_LEN'(1);

  typedef enum logic [2:0] {
    StIdle,
    StToX,
    StToA,
`ifdef MON_EXP_SKIP_LZ_EN
    StScan,
`endif
    StSqr,
    StMul,
    StFrom,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic               pend_q, pend_d;         // a product request is outstanding
  logic               mp_start_q, mp_start_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [BIT_LEN-1:0] x_q, m_q, r2_q, xm_q, am_q, p_q;
  logic [EXP_LEN-1:0] e_q;

  logic               latch_op, cap_xm, cap_am, cap_p, capture, e_bit, is_prod;
  logic [EXP_LEN-1:0] e_sh;
  state_e             step_state;
  logic [CNT_W-1:0]   step_idx;

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pend_q     <= 1'b0;
      mp_start_q <= 1'b0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      mp_start_q <= mp_start_d;
      idx_q      <= idx_d;
    end
  end

  // Next-state logic; leaving one product state issues the next product on the same edge.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    mp_start_d = 1'b0;
    idx_d      = idx_q;
    latch_op   = 1'b0;
    cap_xm     = 1'b0;
    cap_am     = 1'b0;
    cap_p      = 1'b0;
    e_sh       = e_q >> idx_q;
    e_bit      = e_sh[0];
    // mp_done counts only in a wait phase, never in the issue cycle itself.
    capture    = pend_q && !mp_start_q && mp_done;
    if (idx_q == '0) begin
      step_state = StFrom;
      step_idx   = idx_q;
    end else begin
      step_state = StSqr;
      step_idx   = idx_q - CNT_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StToX;
          idx_d    = CNT_W'(EXP_LEN - 1);
          latch_op = 1'b1;
        end
      end
      StToX: begin
        // First product: operands were latched on the previous edge, issue now.
        if (!pend_q) begin
          mp_start_d = 1'b1;
          pend_d     = 1'b1;
        end else if (capture) begin
          cap_xm     = 1'b1;
          state_d    = StToA;
          mp_start_d = 1'b1;
        end
      end
      StToA: begin
        if (capture) begin
          cap_am = 1'b1;
`ifdef MON_EXP_SKIP_LZ_EN
          state_d = StScan;
          pend_d  = 1'b0;
`else
          state_d    = StSqr;
          mp_start_d = 1'b1;
`endif
        end
      end
`ifdef MON_EXP_SKIP_LZ_EN
      StScan: begin
        if (e_bit) begin
          state_d    = StSqr;
          mp_start_d = 1'b1;
          pend_d     = 1'b1;
        end else if (idx_q == '0) begin
          state_d    = StFrom;
          mp_start_d = 1'b1;
          pend_d     = 1'b1;
        end else begin
          idx_d = idx_q - CNT_W'(1);
        end
      end
`endif
      StSqr: begin
        if (capture) begin
          cap_am     = 1'b1;
          mp_start_d = 1'b1;
          if (e_bit) begin
            state_d = StMul;
          end else begin
            state_d = step_state;
            idx_d   = step_idx;
          end
        end
      end
      StMul: begin
        if (capture) begin
          cap_am     = 1'b1;
          mp_start_d = 1'b1;
          state_d    = step_state;
          idx_d      = step_idx;
        end
      end
      StFrom: begin
        if (capture) begin
          cap_p   = 1'b1;
          state_d = StDone;
          pend_d  = 1'b0;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        pend_d  = 1'b0;
      end
    endcase
  end

  // Operand and result registers; only loaded on request latch or product capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q  <= '0;
      e_q  <= '0;
      m_q  <= '0;
      r2_q <= '0;
      xm_q <= '0;
      am_q <= '0;
      p_q  <= '0;
    end else begin
      if (latch_op) begin
        x_q  <= X;
        e_q  <= E;
        m_q  <= M;
        r2_q <= R2;
      end
      if (cap_xm) xm_q <= mp_p;
      if (cap_am) am_q <= mp_p;
      if (cap_p)  p_q  <= mp_p;
    end
  end

  // Product operands come straight from registers, so they hold for the whole request.
  always_comb begin
    mp_a    = '0;
    mp_b    = '0;
    is_prod = 1'b1;
    unique case (state_q)
      StToX: begin
        mp_a = x_q;
        mp_b = r2_q;
      end
      StToA: begin
        mp_a = One;
        mp_b = r2_q;
      end
      StSqr: begin
        mp_a = am_q;
        mp_b = am_q;
      end
      StMul: begin
        mp_a = am_q;
        mp_b = xm_q;
      end
      StFrom: begin
        mp_a = am_q;
        mp_b = One;
      end
      default: is_prod = 1'b0;
    endcase
    mp_m = is_prod ? m_q : '0;
  end

  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign P        = p_q;
  assign mp_start = mp_start_q;

endmodule

// File: tb/tb_mon_exp_ctrl.sv
module tb_mon_exp_ctrl;
  localparam int BL  = 8;
  localparam int EL  = 8;
  localparam int CW  = 4;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [BL-1:0] x = '0, m = 8'd13, r2 = 8'd3;
  logic [EL-1:0] e = '0;
  logic          busy, done, mp_start, mp_done;
  logic [BL-1:0] p, mp_a, mp_b, mp_m, mp_p;

  mon_exp_ctrl #(.BIT_LEN(BL), .EXP_LEN(EL), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .X(x), .E(e), .M(m), .R2(r2),
    .busy(busy), .done(done), .P(p), .mp_start(mp_start), .mp_a(mp_a), .mp_b(mp_b),
    .mp_m(mp_m), .mp_done(mp_done), .mp_p(mp_p)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int starts = 0;
  logic [BL-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  // Behavioural MonPro: a*b*R^-1 mod m with R = 2^BL.
  function automatic logic [BL-1:0] monpro(input logic [BL-1:0] a, b, mm);
    int rinv = 0;
    if (mm == 0) return '0;
    for (int k = 1; k < int'(mm); k++)
      if (((1 << BL) * k) % int'(mm) == 1) rinv = k;
    return BL'((int'(a) * int'(b) * rinv) % int'(mm));
  endfunction

  // Product unit model: mp_done arrives LAT cycles after the mp_start cycle.
  logic          pu_busy = 1'b0, pu_done = 1'b0, pu_ext = 1'b0;
  logic          inj_done = 1'b0, hold2 = 1'b0, chk_en = 1'b1;
  int            pu_cnt = 0;
  logic [BL-1:0] pu_a = '0, pu_b = '0, pu_m = '0, pu_p = '0;

  assign mp_done = pu_done | inj_done;
  assign mp_p    = inj_done ? 8'hAA : pu_p;

  always @(posedge clk) begin
    if (pu_done && hold2 && !pu_ext) begin
      pu_done <= 1'b1;
      pu_ext  <= 1'b1;
    end else begin
      pu_done <= 1'b0;
      pu_ext  <= 1'b0;
    end
    if (mp_start) begin
      pu_busy <= 1'b1;
      pu_cnt  <= 1;
      pu_a    <= mp_a;
      pu_b    <= mp_b;
      pu_m    <= mp_m;
    end else if (pu_busy) begin
      if (pu_cnt == LAT - 1) begin
        pu_busy <= 1'b0;
        pu_done <= 1'b1;
        pu_p    <= monpro(pu_a, pu_b, pu_m);
      end else begin
        pu_cnt <= pu_cnt + 1;
      end
    end
  end

  // Handshake monitor: one request at a time, operands stable while outstanding.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      if (mp_start) begin
        starts++;
        if (pu_busy) fail("mp_start while a request is outstanding");
      end else if (pu_busy) begin
        check("mp_a stable", mp_a, pu_a);
        check("mp_b stable", mp_b, pu_b);
        check("mp_m stable", mp_m, pu_m);
      end
    end
  end

  function automatic int exp_lat(input logic [EL-1:0] ev, input int n);
    int lat = n * (LAT + 1) + 2;
`ifdef MON_EXP_SKIP_LZ_EN
    int h = -1;
    for (int k = 0; k < EL; k++) if (ev[k]) h = k;
    lat += (h < 0) ? EL : (EL - h);
`endif
    return lat;
  endfunction

  // One exponentiation: push expected P at start, pop and compare at done.
  task automatic run_op(input logic [BL-1:0] xv, input logic [EL-1:0] ev,
                        input logic [BL-1:0] pv, input int n_exp, input bit mid);
    bit got = 0;
    int s0;
    logic [BL-1:0] want;
    @(negedge clk);
    x = xv;
    e = ev;
    start = 1'b1;
    exp_q.push_back(pv);
    s0 = starts;
    for (int cyc = 1; cyc <= 1000 && !got; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 1) begin
        x = ~xv;
        e = '0;
      end
      if (mid && cyc == 10) begin
        x = 8'd1;
        e = 8'd1;
        start = 1'b1;
      end
      if (done) begin
        got = 1;
        check("latency", cyc, exp_lat(ev, n_exp));
        if (exp_q.size() == 0) begin
          fail("done with empty scoreboard");
        end else begin
          want = exp_q.pop_front();
          check("P", p, want);
        end
      end else begin
        check("busy during run", busy, 1);
      end
    end
    if (!got) begin
      fail("done timeout");
      exp_q.delete();
    end
    check("mp_start count", starts - s0, n_exp);
    @(negedge clk);
    check("done one cycle", done, 0);
    check("busy after done", busy, 0);
  endtask

  typedef struct {
    logic [BL-1:0] x;
    logic [EL-1:0] e;
    logic [BL-1:0] p;
    int            n_def;
    int            n_skip;
  } vec_t;

  vec_t vecs[5];

  function automatic int n_of(input vec_t v);
`ifdef MON_EXP_SKIP_LZ_EN
    return v.n_skip;
`else
    return v.n_def;
`endif
  endfunction

  initial begin
    vecs[0] = '{x: 8'd5,  e: 8'd3,   p: 8'd8, n_def: 13, n_skip: 7};
    vecs[1] = '{x: 8'd7,  e: 8'd0,   p: 8'd1, n_def: 11, n_skip: 3};
    vecs[2] = '{x: 8'd2,  e: 8'd255, p: 8'd8, n_def: 19, n_skip: 19};
    vecs[3] = '{x: 8'd3,  e: 8'd5,   p: 8'd9, n_def: 13, n_skip: 8};
    vecs[4] = '{x: 8'd11, e: 8'd128, p: 8'd9, n_def: 12, n_skip: 12};

    // Reset state.
    #12;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset P", p, 0);
    check("reset mp_start", mp_start, 0);
    check("reset mp_a", mp_a, 0);
    check("reset mp_b", mp_b, 0);
    check("reset mp_m", mp_m, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i].x, vecs[i].e, vecs[i].p, n_of(vecs[i]), 1'b0);

    // Second start mid-run is ignored.
    run_op(8'd5, 8'd3, 8'd8, n_of(vecs[0]), 1'b1);

    // Asynchronous abort during a wait phase, then a stray mp_done.
    @(negedge clk);
    x = 8'd5;
    e = 8'd3;
    start = 1'b1;
    exp_q.push_back(8'd8);
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("wait phase before abort", busy, 1);
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort P", p, 0);
    check("abort mp_start", mp_start, 0);
    check("abort mp_a", mp_a, 0);
    check("abort mp_b", mp_b, 0);
    check("abort mp_m", mp_m, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("post-abort busy", busy, 0);
      check("post-abort done", done, 0);
      check("post-abort mp_start", mp_start, 0);
    end
    chk_en = 1'b1;
    run_op(8'd5, 8'd3, 8'd8, n_of(vecs[0]), 1'b0);

    // Spurious mp_done in IDLE.
    @(negedge clk);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    check("idle stray busy", busy, 0);
    check("idle stray mp_start", mp_start, 0);
    @(negedge clk);
    check("idle stray done", done, 0);
    check("idle stray P", p, 8);

    // mp_done held two cycles on every product.
    hold2 = 1'b1;
    run_op(8'd5, 8'd3, 8'd8, n_of(vecs[0]), 1'b0);
    hold2 = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    fail("global timeout");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
